umem_arbiter: RTL and testbench

Arbitrates one single-ported unified instruction/data memory between the Fetch stage and the Memory stage of the pipelined core. Data accesses take fixed priority over fetches. Each access is sequenced through a request/acknowledge handshake with the memory. The block raises stall requests that the hazard unit ORs into StallF and StallD/StallE/StallM.

---
 rtl/umem_pkg.sv | 16 +
 rtl/umem_fetch_buf.sv | 50 +++++
 rtl/umem_arbiter.sv | 159 +++++++++++++++
 tb/tb_umem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/umem_pkg.sv
// umem_pkg: shared types and default widths for the unified memory arbiter.
//   umem_state_e  : arbiter FSM state encoding
//   UMEM_ADDR_W   : default byte address width
//   UMEM_DATA_W   : default word width
package umem_pkg;

  localparam int UMEM_ADDR_W = 32;
  localparam int UMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DATA  = 2'b10
  } umem_state_e;

endpackage

// File: rtl/umem_fetch_buf.sv
// umem_fetch_buf: one-entry buffer holding the last completed, unkilled
// fetch, plus the address compare used for a buffer hit. Only instantiated
// when UMEM_ARB_FETCH_BUF_EN is defined.
// Ports:
//   clk, reset_n    clock, async active-low reset (clears the valid bit)
//   fill            capture {mem_addr, fill_data} as the new entry
//   fill_data       instruction returned by memory
//   inval           store completing at mem_addr; drop the entry on a match
//   mem_addr        address of the access currently completing
//   lookup_addr     fetch address to compare against the entry
//   hit, hit_data   entry valid and matching, and its stored instruction
module umem_fetch_buf
  import umem_pkg::*;
#(
  parameter int ADDR_W = UMEM_ADDR_W,
  parameter int DATA_W = UMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inval,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (fill) begin
      buf_valid <= 1'b1;
      buf_addr  <= mem_addr;
      buf_data  <= fill_data;
    end else if (inval && (mem_addr == buf_addr)) begin
      buf_valid <= 1'b0;
    end
  end

  assign hit      = buf_valid && (lookup_addr == buf_addr);
  assign hit_data = buf_data;

endmodule

// File: rtl/umem_arbiter.sv
// umem_arbiter: shares one single-ported instruction/data memory between
// the Fetch and Memory stages. Data accesses win over fetches; each access
// is a MemReq/MemAck handshake, and stall requests go to the hazard unit.
// Optional feature macro: UMEM_ARB_FETCH_BUF_EN adds a one-entry fetch
// buffer (umem_fetch_buf) that answers repeated fetches without memory.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   FetchReq/FetchAddr/FetchKill      fetch request, address, PC redirect
//   FetchValid/FetchRdata             fetch completion pulse and data
//   DataReq/DataWe/DataAddr/DataWdata load/store request from Memory stage
//   DataValid/DataRdata               data completion pulse and load data
//   StallFetchReq/StallMemReq         unserved-request stalls (combinational)
//   MemReq/MemWe/MemAddr/MemWdata     memory request, held until MemAck
//   MemAck/MemRdata                   memory completion strobe and read data
//
// state | meaning
// IDLE  | no access in flight; arbitrate pending requests
// FETCH | instruction read in flight, waiting for MemAck
// DATA  | load/store in flight, waiting for MemAck
module umem_arbiter
  import umem_pkg::*;
#(
  parameter int ADDR_W = UMEM_ADDR_W,
  parameter int DATA_W = UMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] FetchAddr,
  input  logic              FetchKill,
  output logic              FetchValid,
  output logic [DATA_W-1:0] FetchRdata,
  input  logic              DataReq,
  input  logic              DataWe,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic [DATA_W-1:0] DataWdata,
  output logic              DataValid,
  output logic [DATA_W-1:0] DataRdata,
  output logic              StallFetchReq,
  output logic              StallMemReq,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRdata
);

  umem_state_e state;
  logic        killed;
  logic        fetch_pend;
  logic        data_pend;
  logic        buf_hit;
  logic [DATA_W-1:0] buf_data;

  // A request whose Valid pulse is showing this cycle is already served;
  // the requester still holds Req during that cycle, so it must not be
  // re-issued from IDLE.
  assign fetch_pend = FetchReq & ~FetchValid;
  assign data_pend  = DataReq & ~DataValid;

  assign StallFetchReq = fetch_pend;
  assign StallMemReq   = data_pend;

`ifdef UMEM_ARB_FETCH_BUF_EN
  logic buf_fill;
  logic buf_inval;

  assign buf_fill  = (state == FETCH) && MemAck && !killed && !FetchKill;
  assign buf_inval = (state == DATA) && MemAck && MemWe;

  umem_fetch_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fetch_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .fill        (buf_fill),
    .fill_data   (MemRdata),
    .inval       (buf_inval),
    .mem_addr    (MemAddr),
    .lookup_addr (FetchAddr),
    .hit         (buf_hit),
    .hit_data    (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      killed     <= 1'b0;
      MemReq     <= 1'b0;
      MemWe      <= 1'b0;
      MemAddr    <= '0;
      MemWdata   <= '0;
      FetchValid <= 1'b0;
      FetchRdata <= '0;
      DataValid  <= 1'b0;
      DataRdata  <= '0;
    end else begin
      FetchValid <= 1'b0;
      DataValid  <= 1'b0;
      case (state)
        IDLE: begin
          if (data_pend) begin
            state    <= DATA;
            MemReq   <= 1'b1;
            MemWe    <= DataWe;
            MemAddr  <= DataAddr;
            MemWdata <= DataWdata;
          end else if (fetch_pend) begin
            if (buf_hit) begin
              FetchValid <= 1'b1;
              FetchRdata <= buf_data;
            end else begin
              state    <= FETCH;
              MemReq   <= 1'b1;
              MemWe    <= 1'b0;
              MemAddr  <= FetchAddr;
              MemWdata <= '0;
            end
          end
        end
        FETCH: begin
          if (MemAck) begin
            state  <= IDLE;
            MemReq <= 1'b0;
            killed <= 1'b0;
            // A kill landing in the ack cycle drops the response as well.
            if (!killed && !FetchKill) begin
              FetchValid <= 1'b1;
              FetchRdata <= MemRdata;
            end
          end else if (FetchKill) begin
            killed <= 1'b1;
          end
        end
        DATA: begin
          if (MemAck) begin
            state     <= IDLE;
            MemReq    <= 1'b0;
            DataValid <= 1'b1;
            if (!MemWe) begin
              DataRdata <= MemRdata;
            end
          end
        end
        default: begin
          state  <= IDLE;
          MemReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_umem_arbiter.sv
// tb_umem_arbiter: scoreboard bench for umem_arbiter. Stimulus pushes the
// expected memory requests and responses; a monitor pops and compares them
// whenever the DUT raises MemReq, FetchValid or DataValid.
module tb_umem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        FetchReq = 1'b0;
  logic [31:0] FetchAddr = '0;
  logic        FetchKill = 1'b0;
  logic        FetchValid;
  logic [31:0] FetchRdata;
  logic        DataReq = 1'b0;
  logic        DataWe = 1'b0;
  logic [31:0] DataAddr = '0;
  logic [31:0] DataWdata = '0;
  logic        DataValid;
  logic [31:0] DataRdata;
  logic        StallFetchReq;
  logic        StallMemReq;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic        MemAck;
  logic [31:0] MemRdata;

  mreq_t       mreq_q[$];
  logic [31:0] fetch_q[$];
  logic [31:0] data_q[$];
  logic [31:0] mem [logic [31:0]];

  int   n_cmp = 0;
  int   n_err = 0;
  int   mem_delay = 1;
  logic stray_ack = 1'b0;
  logic mreq_prev = 1'b0;

  umem_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .FetchReq      (FetchReq),
    .FetchAddr     (FetchAddr),
    .FetchKill     (FetchKill),
    .FetchValid    (FetchValid),
    .FetchRdata    (FetchRdata),
    .DataReq       (DataReq),
    .DataWe        (DataWe),
    .DataAddr      (DataAddr),
    .DataWdata     (DataWdata),
    .DataValid     (DataValid),
    .DataRdata     (DataRdata),
    .StallFetchReq (StallFetchReq),
    .StallMemReq   (StallMemReq),
    .MemReq        (MemReq),
    .MemWe         (MemWe),
    .MemAddr       (MemAddr),
    .MemWdata      (MemWdata),
    .MemAck        (MemAck),
    .MemRdata      (MemRdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [71:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got 0x%0h, want no response", name, act);
  endtask

  // Memory model: acks mem_delay cycles after MemReq first appears.
  initial begin
    int   cnt;
    logic acked;
    cnt = 0;
    acked = 1'b0;
    MemAck = 1'b0;
    MemRdata = '0;
    forever begin
      @(posedge clk);
      #1;
      MemAck = 1'b0;
      if (!MemReq) begin
        cnt = 0;
        acked = 1'b0;
      end else if (!acked) begin
        if (cnt == mem_delay) begin
          MemAck = 1'b1;
          acked = 1'b1;
          if (MemWe) begin
            MemRdata = 32'hBAD0_BAD0;
            mem[MemAddr] = MemWdata;
          end else begin
            MemRdata = mem.exists(MemAddr) ? mem[MemAddr] : 32'h0;
          end
        end else begin
          cnt++;
        end
      end
      if (stray_ack) MemAck = 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    mreq_t held;
    mreq_t exp;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mreq_prev = 1'b0;
      end else begin
        if (MemReq && !mreq_prev) begin
          held = '{we: MemWe, addr: MemAddr, wdata: MemWdata};
          if (mreq_q.size() == 0) unexpected("mem_req", 72'(held));
          else begin
            exp = mreq_q.pop_front();
            chk("mem_we", 72'(MemWe), 72'(exp.we));
            chk("mem_addr", 72'(MemAddr), 72'(exp.addr));
            chk("mem_wdata", 72'(MemWdata), 72'(exp.wdata));
          end
        end else if (MemReq) begin
          chk("mem_stable", 72'({MemWe, MemAddr, MemWdata}), 72'(held));
        end
        mreq_prev = MemReq;
        if (FetchValid) begin
          if (fetch_q.size() == 0) unexpected("fetch_valid", 72'(FetchRdata));
          else chk("fetch_rdata", 72'(FetchRdata), 72'(fetch_q.pop_front()));
        end
        if (DataValid) begin
          if (data_q.size() == 0) unexpected("data_valid", 72'(DataRdata));
          else chk("data_rdata", 72'(DataRdata), 72'(data_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    mreq_q.push_back('{we: we, addr: addr, wdata: wdata});
  endtask

  task automatic wait_fetch(input int exp_lat);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (FetchValid) begin
        done = 1'b1;
        chk("fetch_stall_at_valid", 72'(StallFetchReq), 72'(0));
        chk("fetch_latency", 72'(n), 72'(exp_lat));
      end else begin
        chk("fetch_stall_wait", 72'(StallFetchReq), 72'(1));
      end
    end
    if (!done) chk("fetch_timeout", 72'(FetchValid), 72'(1));
  endtask

  task automatic wait_data(input int exp_lat);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (DataValid) begin
        done = 1'b1;
        chk("data_stall_at_valid", 72'(StallMemReq), 72'(0));
        chk("data_latency", 72'(n), 72'(exp_lat));
      end else begin
        chk("data_stall_wait", 72'(StallMemReq), 72'(1));
      end
    end
    if (!done) chk("data_timeout", 72'(DataValid), 72'(1));
  endtask

  // Callers are at posedge+1 and have already queued the MemReq expectation.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_data, input int exp_lat);
    fetch_q.push_back(exp_data);
    FetchReq = 1'b1;
    FetchAddr = addr;
    #1;
    chk("fetch_stall_req", 72'(StallFetchReq), 72'(1));
    wait_fetch(exp_lat);
    @(posedge clk);
    #1;
    FetchReq = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input int exp_lat);
    data_q.push_back(exp_rdata);
    DataReq = 1'b1;
    DataWe = we;
    DataAddr = addr;
    DataWdata = wdata;
    #1;
    chk("data_stall_req", 72'(StallMemReq), 72'(1));
    wait_data(exp_lat);
    @(posedge clk);
    #1;
    DataReq = 1'b0;
    DataWe = 1'b0;
  endtask

  initial begin
    mem[32'h100] = 32'hE3A0_1005;
    mem[32'h104] = 32'hE59F_1004;
    mem[32'h108] = 32'hEAFF_FFFE;
    mem[32'h10C] = 32'hE12F_FF1E;
    mem[32'h300] = 32'hE1A0_0000;
    mem[32'h304] = 32'hE350_0000;
    mem[32'h400] = 32'hE281_1001;
    mem[32'h204] = 32'hDEAD_BEEF;
    mem[32'h208] = 32'h1234_5678;

    // Reset held with a fetch pending: everything stays at 0.
    FetchReq = 1'b1;
    FetchAddr = 32'h100;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mem", 72'({MemReq, MemWe, MemAddr, MemWdata}), 72'(0));
      chk("rst_fetch", 72'({FetchValid, FetchRdata}), 72'(0));
      chk("rst_data", 72'({DataValid, DataRdata}), 72'(0));
    end

    // Release: fetch 0x100 issued at once, ack 2 cycles after MemReq.
    mem_delay = 2;
    exp_mem(1'b0, 32'h100, 32'h0);
    fetch_q.push_back(32'hE3A0_1005);
    reset_n = 1'b1;
    wait_fetch(4);
    @(posedge clk);
    #1;
    FetchReq = 1'b0;
    idle(2);

    // Store and fetch in the same cycle: store goes first.
    mem_delay = 1;
    exp_mem(1'b1, 32'h200, 32'h55);
    exp_mem(1'b0, 32'h104, 32'h0);
    fork
      do_data(1'b1, 32'h200, 32'h55, 32'h0, 3);
      do_fetch(32'h104, 32'hE59F_1004, 6);
    join
    idle(2);

    // Load.
    exp_mem(1'b0, 32'h204, 32'h0);
    do_data(1'b0, 32'h204, 32'h0, 32'hDEAD_BEEF, 3);
    idle(2);

    // Kill mid-flight, then redirect to 0x300.
    mem_delay = 3;
    exp_mem(1'b0, 32'h108, 32'h0);
    exp_mem(1'b0, 32'h300, 32'h0);
    FetchReq = 1'b1;
    FetchAddr = 32'h108;
    idle(2);
    FetchKill = 1'b1;
    FetchAddr = 32'h300;
    idle(1);
    FetchKill = 1'b0;
    fetch_q.push_back(32'hE1A0_0000);
    wait_fetch(7);
    @(posedge clk);
    #1;
    FetchReq = 1'b0;
    idle(2);

    // Kill in the same cycle as MemAck, then redirect to 0x304.
    mem_delay = 1;
    exp_mem(1'b0, 32'h10C, 32'h0);
    exp_mem(1'b0, 32'h304, 32'h0);
    FetchReq = 1'b1;
    FetchAddr = 32'h10C;
    idle(2);
    FetchKill = 1'b1;
    FetchAddr = 32'h304;
    idle(1);
    FetchKill = 1'b0;
    fetch_q.push_back(32'hE350_0000);
    wait_fetch(3);
    @(posedge clk);
    #1;
    FetchReq = 1'b0;
    idle(2);

    // Minimum latency: ack in the first MemReq cycle.
    mem_delay = 0;
    exp_mem(1'b0, 32'h400, 32'h0);
    do_fetch(32'h400, 32'hE281_1001, 2);
    idle(2);
    exp_mem(1'b0, 32'h208, 32'h0);
    do_data(1'b0, 32'h208, 32'h0, 32'h1234_5678, 2);
    idle(2);

    // Stray MemAck while idle is ignored.
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_memreq", 72'(MemReq), 72'(0));
    chk("stray_ack_valids", 72'({FetchValid, DataValid}), 72'(0));
    idle(1);

    // Reset in the middle of a fetch: MemReq drops, no response later.
    mem_delay = 5;
    exp_mem(1'b0, 32'h104, 32'h0);
    FetchReq = 1'b1;
    FetchAddr = 32'h104;
    idle(2);
    chk("midrst_memreq_before", 72'(MemReq), 72'(1));
    reset_n = 1'b0;
    #1;
    chk("midrst_memreq_after", 72'(MemReq), 72'(0));
    FetchReq = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(8);

`ifdef UMEM_ARB_FETCH_BUF_EN
    // Fetch buffer: miss, hit, store invalidates, miss again.
    mem_delay = 1;
    exp_mem(1'b0, 32'h100, 32'h0);
    do_fetch(32'h100, 32'hE3A0_1005, 3);
    idle(1);
    do_fetch(32'h100, 32'hE3A0_1005, 1);
    idle(1);
    exp_mem(1'b1, 32'h100, 32'h11);
    do_data(1'b1, 32'h100, 32'h11, 32'h1234_5678, 3);
    idle(1);
    exp_mem(1'b0, 32'h100, 32'h0);
    do_fetch(32'h100, 32'h11, 3);
    idle(2);
`endif

    idle(3);
    chk("mreq_q_drained", 72'(mreq_q.size()), 72'(0));
    chk("fetch_q_drained", 72'(fetch_q.size()), 72'(0));
    chk("data_q_drained", 72'(data_q.size()), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
